// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback driver.
package wb_pkg;

  localparam int unsigned WB_AW    = 5;
  localparam int unsigned WB_DW    = 32;
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic [WB_AW-1:0] rw;
    logic [WB_DW-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_ALU
  } wb_src_t;

endpackage

// File: rtl/wb_write_driver_if.sv
// Producer handshakes, regfile write port and forwarding query of wb_write_driver.
interface wb_write_driver_if
  import wb_pkg::*;
#(
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_rw;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_rw;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          hold;
  logic          reg_we;
  logic [AW-1:0] reg_rw;
  logic [DW-1:0] reg_busW;
  logic [AW-1:0] q_ra;
  logic          q_hit;
  logic [DW-1:0] q_data;
  logic [CW-1:0] pending;

  modport slave (
    input  alu_valid, alu_rw, alu_data, mem_valid, mem_rw, mem_data, hold, q_ra,
    output alu_ready, mem_ready, reg_we, reg_rw, reg_busW, q_hit, q_data, pending
  );

  modport master (
    output alu_valid, alu_rw, alu_data, mem_valid, mem_rw, mem_data, hold, q_ra,
    input  alu_ready, mem_ready, reg_we, reg_rw, reg_busW, q_hit, q_data, pending
  );
endinterface

// File: rtl/wb_fifo.sv
// In-order writeback queue; per-entry vectors are exposed for the forwarding search.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [AW-1:0]                 push_rw,
  input  logic [DW-1:0]                 push_data,
  input  logic                          pop,
  output logic [AW-1:0]                 head_rw,
  output logic [DW-1:0]                 head_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic [$clog2(DEPTH)-1:0]      wr_ptr,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][AW-1:0]      ent_rw,
  output logic [DEPTH-1:0][DW-1:0]      ent_data
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] rd_ptr;

  assign head_rw   = ent_rw[rd_ptr];
  assign head_data = ent_data[rd_ptr];

  // Callers never push when full nor pop when empty, so the two pointers never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_rw    <= '0;
      ent_data  <= '0;
    end else begin
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_rw[wr_ptr]    <= push_rw;
        ent_data[wr_ptr]  <= push_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/wb_write_driver.sv
// Regfile write-port initiator: mem/alu arbitration, queue, output stage, forwarding.
// Optional macro WB_BYPASS_EN: an empty, unheld queue lets a request load the output stage directly.
module wb_write_driver
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_write_driver_if.slave   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]            count;
  logic [PW-1:0]            wr_ptr;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_rw;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [AW-1:0]            head_rw;
  logic [DW-1:0]            head_data;

  logic          full, acc_keep, push, pop, bypass;
  wb_src_t       src;
  logic [AW-1:0] acc_rw;
  logic [DW-1:0] acc_data;

  logic          out_we;
  logic [AW-1:0] out_rw;
  logic [DW-1:0] out_data;

  logic          q_hit_c;
  logic [DW-1:0] q_data_c;
  logic [PW-1:0] idx;

  assign full          = (count == CW'(DEPTH));
  assign bus.mem_ready = rst_n && !full;
  assign bus.alu_ready = rst_n && !full && !bus.mem_valid;

  always_comb begin
    src      = SRC_NONE;
    acc_rw   = '0;
    acc_data = '0;
    if (bus.mem_valid && bus.mem_ready) begin
      src      = SRC_MEM;
      acc_rw   = bus.mem_rw;
      acc_data = bus.mem_data;
    end else if (bus.alu_valid && bus.alu_ready) begin
      src      = SRC_ALU;
      acc_rw   = bus.alu_rw;
      acc_data = bus.alu_data;
    end
  end

  assign acc_keep = (src != SRC_NONE) && (acc_rw != AW'(REG_ZERO));
  assign pop      = !bus.hold && (count != '0);

`ifdef WB_BYPASS_EN
  assign bypass = (count == '0) && !bus.hold;
`else
  assign bypass = 1'b0;
`endif

  assign push = acc_keep && !bypass;

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_rw   (acc_rw),
    .push_data (acc_data),
    .pop       (pop),
    .head_rw   (head_rw),
    .head_data (head_data),
    .count     (count),
    .wr_ptr    (wr_ptr),
    .ent_valid (ent_valid),
    .ent_rw    (ent_rw),
    .ent_data  (ent_data)
  );

  // Bypass only fires on an empty queue, so it never competes with a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_we   <= 1'b0;
      out_rw   <= '0;
      out_data <= '0;
    end else if (bypass && acc_keep) begin
      out_we   <= 1'b1;
      out_rw   <= acc_rw;
      out_data <= acc_data;
    end else if (pop) begin
      out_we   <= 1'b1;
      out_rw   <= head_rw;
      out_data <= head_data;
    end else begin
      out_we   <= 1'b0;
    end
  end

  // Walk backwards from the newest slot so the youngest matching write wins.
  always_comb begin
    q_hit_c  = 1'b0;
    q_data_c = '0;
    idx      = '0;
    if (bus.q_ra != AW'(REG_ZERO)) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx = wr_ptr - PW'(k) - PW'(1);
        if (!q_hit_c && ent_valid[idx] && ent_rw[idx] == bus.q_ra) begin
          q_hit_c  = 1'b1;
          q_data_c = ent_data[idx];
        end
      end
      if (!q_hit_c && out_we && out_rw == bus.q_ra) begin
        q_hit_c  = 1'b1;
        q_data_c = out_data;
      end
    end
  end

  assign bus.reg_we   = out_we;
  assign bus.reg_rw   = out_rw;
  assign bus.reg_busW = out_data;
  assign bus.q_hit    = q_hit_c;
  assign bus.q_data   = q_data_c;
  assign bus.pending  = count;
endmodule

// File: tb/tb_wb_write_driver.sv
// Self-checking bench for wb_write_driver: vector table, directed corner cases, random vs queue model.
module tb_wb_write_driver;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  wb_write_driver_if #(.AW(5), .DW(32), .DEPTH(DEPTH)) bus ();

  wb_write_driver #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pending queue plus the visible write-port state.
  wb_req_t     mq[$];
  logic        m_we;
  logic [4:0]  m_rw;
  logic [31:0] m_data;
  wb_req_t     clog[$];
  logic [31:0] dut_rf[32];

  typedef struct {
    logic av; logic [4:0] arw; logic [31:0] ad;
    logic mv; logic [4:0] mrw; logic [31:0] md;
    logic hold; logic [4:0] qra;
    logic e_ar; logic e_mr; logic e_we; logic [4:0] e_rw; logic [31:0] e_d;
    logic [2:0] e_pend; logic e_hit; logic [31:0] e_qd;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] arw, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrw, input logic [31:0] md,
                       input logic hold, input logic [4:0] qra);
    bus.alu_valid = av;  bus.alu_rw = arw;  bus.alu_data = ad;
    bus.mem_valid = mv;  bus.mem_rw = mrw;  bus.mem_data = md;
    bus.hold = hold;     bus.q_ra = qra;
  endtask

  task automatic model_clear();
    mq.delete();
    m_we = 1'b0; m_rw = '0; m_data = '0;
  endtask

  task automatic model_update();
    int      cnt;
    bit      acc;
    wb_req_t r, h;
    if (!rst_n) begin
      model_clear();
      return;
    end
    cnt = mq.size();
    acc = 1'b0;
    r   = '0;
    if (bus.mem_valid && cnt < DEPTH) begin
      acc = 1'b1; r.rw = bus.mem_rw; r.data = bus.mem_data;
    end else if (bus.alu_valid && cnt < DEPTH) begin
      acc = 1'b1; r.rw = bus.alu_rw; r.data = bus.alu_data;
    end
    if (!bus.hold && cnt > 0) begin
      h = mq.pop_front();
      m_we = 1'b1; m_rw = h.rw; m_data = h.data;
    end else begin
      m_we = 1'b0;
    end
    if (acc && r.rw != 0) begin
      if (BYP && cnt == 0 && !bus.hold) begin
        m_we = 1'b1; m_rw = r.rw; m_data = r.data;
      end else begin
        mq.push_back(r);
      end
    end
  endtask

  task automatic mid_check();
    logic        e_mr, e_ar, e_hit;
    logic [31:0] e_qd;
    e_mr  = rst_n && (mq.size() < DEPTH);
    e_ar  = e_mr && !bus.mem_valid;
    e_hit = 1'b0;
    e_qd  = '0;
    if (bus.q_ra != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!e_hit && mq[i].rw == bus.q_ra) begin
          e_hit = 1'b1; e_qd = mq[i].data;
        end
      end
      if (!e_hit && m_we && m_rw == bus.q_ra) begin
        e_hit = 1'b1; e_qd = m_data;
      end
    end
    chk("mdl_mem_ready", bus.mem_ready, e_mr);
    chk("mdl_alu_ready", bus.alu_ready, e_ar);
    chk("mdl_reg_we",    bus.reg_we,    m_we);
    chk("mdl_reg_rw",    bus.reg_rw,    m_rw);
    chk("mdl_reg_busW",  bus.reg_busW,  m_data);
    chk("mdl_pending",   bus.pending,   mq.size());
    chk("mdl_q_hit",     bus.q_hit,     e_hit);
    chk("mdl_q_data",    bus.q_data,    e_qd);
  endtask

  task automatic tick();
    wb_req_t c;
    if (bus.reg_we === 1'b1) begin
      c.rw = bus.reg_rw; c.data = bus.reg_busW;
      clog.push_back(c);
      dut_rf[bus.reg_rw] = bus.reg_busW;
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    #3;
    mid_check();
    tick();
  endtask

  task automatic idle(input int n, input logic hold);
    drive(0, 0, 0, 0, 0, 0, hold, 0);
    repeat (n) cycle();
  endtask

  initial begin
    int found;
    tests = 0;
    fails = 0;
    model_clear();
    foreach (dut_rf[i]) dut_rf[i] = '0;

    tbl[0]  = '{1,1,32'hA1, 0,0,0,      1,0, 1,1,0,0,0,        0,0,0};
    tbl[1]  = '{1,9,32'h99, 1,2,32'hB2, 1,1, 0,1,0,0,0,        1,1,32'hA1};
    tbl[2]  = '{1,3,32'hC3, 0,0,0,      1,0, 1,1,0,0,0,        2,0,0};
    tbl[3]  = '{0,0,0,      1,4,32'hD4, 1,2, 0,1,0,0,0,        3,1,32'hB2};
    tbl[4]  = '{1,5,32'h55, 1,6,32'h66, 1,3, 0,0,0,0,0,        4,1,32'hC3};
    tbl[5]  = '{0,0,0,      0,0,0,      0,4, 0,0,0,0,0,        4,1,32'hD4};
    tbl[6]  = '{1,7,32'h77, 0,0,0,      0,1, 1,1,1,1,32'hA1,   3,1,32'hA1};
    tbl[7]  = '{0,0,0,      0,0,0,      0,7, 1,1,1,2,32'hB2,   3,1,32'h77};
    tbl[8]  = '{0,0,0,      0,0,0,      0,0, 1,1,1,3,32'hC3,   2,0,0};
    tbl[9]  = '{0,0,0,      0,0,0,      0,7, 1,1,1,4,32'hD4,   1,1,32'h77};
    tbl[10] = '{0,0,0,      0,0,0,      0,7, 1,1,1,7,32'h77,   0,1,32'h77};
    tbl[11] = '{0,0,0,      0,0,0,      0,7, 1,1,0,7,32'h77,   0,0,0};

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_alu_ready", bus.alu_ready, 1'b0);
    chk("rst_mem_ready", bus.mem_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_we",   bus.reg_we,   1'b0);
    chk("rst_reg_rw",   bus.reg_rw,   5'd0);
    chk("rst_reg_busW", bus.reg_busW, 32'd0);
    chk("rst_pending",  bus.pending,  3'd0);
    rst_n = 1'b1;

    // Vector table: fill under hold, full, then drain in order
    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].arw, tbl[i].ad, tbl[i].mv, tbl[i].mrw, tbl[i].md,
            tbl[i].hold, tbl[i].qra);
      #3;
      mid_check();
      chk($sformatf("tbl%0d_alu_ready", i), bus.alu_ready, tbl[i].e_ar);
      chk($sformatf("tbl%0d_mem_ready", i), bus.mem_ready, tbl[i].e_mr);
      chk($sformatf("tbl%0d_reg_we", i),    bus.reg_we,    tbl[i].e_we);
      chk($sformatf("tbl%0d_reg_rw", i),    bus.reg_rw,    tbl[i].e_rw);
      chk($sformatf("tbl%0d_reg_busW", i),  bus.reg_busW,  tbl[i].e_d);
      chk($sformatf("tbl%0d_pending", i),   bus.pending,   tbl[i].e_pend);
      chk($sformatf("tbl%0d_q_hit", i),     bus.q_hit,     tbl[i].e_hit);
      chk($sformatf("tbl%0d_q_data", i),    bus.q_data,    tbl[i].e_qd);
      tick();
    end

    // Single ALU write latency
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    found = 0;
    for (int n = 1; n <= 10 && found == 0; n++) begin
      #3;
      mid_check();
      if (bus.reg_we === 1'b1) begin
        found = n;
        chk("lat_reg_rw",   bus.reg_rw,   5'd5);
        chk("lat_reg_busW", bus.reg_busW, 32'hDEADBEEF);
      end
      tick();
    end
    chk("lat_cycles", found, LAT);
    idle(2, 0);

    // Same-cycle mem/alu conflict on r3
    clog.delete();
    drive(1, 3, 32'h22, 1, 3, 32'h11, 0, 0);
    #3;
    mid_check();
    chk("conf_alu_ready", bus.alu_ready, 1'b0);
    chk("conf_mem_ready", bus.mem_ready, 1'b1);
    tick();
    drive(1, 3, 32'h22, 0, 0, 0, 0, 0);
    cycle();
    idle(4, 0);
    chk("conf_commits", clog.size(), 2);
    chk("conf_first",  {clog[0].rw, clog[0].data}, {5'd3, 32'h11});
    chk("conf_second", {clog[1].rw, clog[1].data}, {5'd3, 32'h22});
    chk("conf_r3",     dut_rf[3], 32'h22);

    // Register zero is handshaked but discarded
    drive(1, 0, 32'h55, 0, 0, 0, 0, 0);
    #3;
    mid_check();
    chk("zero_alu_ready", bus.alu_ready, 1'b1);
    chk("zero_q_hit",     bus.q_hit,     1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      #3;
      mid_check();
      chk("zero_reg_we",  bus.reg_we,  1'b0);
      chk("zero_pending", bus.pending, 3'd0);
      tick();
    end

    // Forwarding returns the youngest of two queued r7 writes
    drive(1, 7, 32'h1, 0, 0, 0, 1, 0);
    cycle();
    drive(1, 7, 32'h2, 0, 0, 0, 1, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    #3;
    mid_check();
    chk("fwd_q_hit",  bus.q_hit,  1'b1);
    chk("fwd_q_data", bus.q_data, 32'h2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    repeat (3) cycle();
    #3;
    mid_check();
    chk("fwd_after_q_hit",  bus.q_hit,  1'b0);
    chk("fwd_after_q_data", bus.q_data, 32'h0);
    tick();

    // Asynchronous reset with three pending writes
    for (int n = 1; n <= 3; n++) begin
      drive(1, 5'(n), 32'(n + 100), 0, 0, 0, 1, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #3;
    chk("arst_pre_pending", bus.pending, 3'd3);
    tick();
    clog.delete();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_reg_we",    bus.reg_we,    1'b0);
    chk("arst_pending",   bus.pending,   3'd0);
    chk("arst_mem_ready", bus.mem_ready, 1'b0);
    model_clear();
    rst_n = 1'b1;
    cycle();
    idle(4, 0);
    chk("arst_no_stale", clog.size(), 0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
      cycle();
    end
    idle(DEPTH + 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
